instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Inverse of the instruction field splitter: packs decoded MIPS fields back into 32-bit instruction words.
//  Accepts one instruction descriptor per valid/ready handshake.
//  Buffers encoded words in a small FIFO, each tagged with its instruction-memory address.
//  Drives a valid/ready stream toward the IM loader and the splitter/decoder bench.
// PARAMETERS
//  FIFO_DEPTH  4             entries in output FIFO; power of two, >=2
//  BASE_ADDR   32'h0000_3000 address tagged onto the first legal word after reset
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-low reset
//  in_valid   in   1   descriptor valid
//  in_ready   out  1   block can accept a descriptor
//  in_kind    in   4   0 NOP,1 ADD,2 SUB,3 ORI,4 LW,5 SW,6 BEQ,7 LUI,8 JAL,9 JR; 10-15 illegal
//  in_rs      in   5   rs field
//  in_rt      in   5   rt field
//  in_rd      in   5   rd field
//  in_imm     in   16  immediate / branch offset
//  in_index   in   26  jump instr_index
//  out_valid  out  1   FIFO head holds a word
//  out_ready  in   1   consumer takes head this cycle
//  out_instr  out  32  encoded word at FIFO head
//  out_addr   out  32  address tagged to head word
//  count      out  16  words popped since reset, saturating
//  err        out  1   sticky: an illegal kind was accepted
// BEHAVIOUR
//  - Reset (reset=0, async): FIFO emptied, out_valid=0, out_instr=0, out_addr=0, count=0, err=0,
//    address counter=BASE_ADDR. in_ready=1 once reset deasserts.
//  - Handshakes: accept when in_valid&&in_ready; pop when out_valid&&out_ready.
//    A source holds in_* stable while in_valid&&!in_ready. out_instr/out_addr stay stable while out_valid&&!out_ready.
//  - in_ready = !full. No bypass when full, even if a pop occurs that cycle.
//  - Simultaneous push+pop when not full or empty: both take effect, and occupancy is unchanged.
//  - Encoding is combinational into the FIFO write. A word accepted at edge N is visible at out_* after edge N
//    (1-cycle latency when empty).
//  - Encoding: R={op,rs,rt,rd,shamt=0,funct}, I={op,rs,rt,imm}, J={op,index}.
//    ADD  op 00 funct 20: {rs,rt,rd}
//    SUB  op 00 funct 22: {rs,rt,rd}
//    JR   op 00 funct 08: rs only; rt, rd forced 0
//    ORI  op 0D, LW op 23, SW op 2B, BEQ op 04: I-format {rs,rt,imm}
//    LUI  op 0F: rs forced 0
//    JAL  op 03: J-format
//    NOP  32'h0
//    Fields a format does not use are ignored (forced 0).
//  - Address counter: tags each legal accepted word, then increments by 4, wrapping mod 2^32.
//  - Illegal kind: the handshake completes, nothing is pushed, the address does not advance, and err latches 1
//    until reset.
//  - count increments on each pop and saturates at 16'hFFFF.
//  - out_instr/out_addr read 0 when the FIFO is empty.
//  - FIFO pointers wrap modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits wide.
//  - Reset asserted mid-stream discards all buffered words. The next legal word is tagged BASE_ADDR.
// TESTING
//  1. ADD rs=9 rt=10 rd=10, out_ready=1 -> next cycle out_valid=1, out_instr=012a5020, out_addr=00003000; count=1 after pop.
//  2. Sequence SUB(11,13,11), ORI(11,11,7f3c), LW(9,12,1234), SW(10,12,5678), BEQ(9,2,9abc), LUI(rt=1,def0), JAL(123456), JR(21):
//     -> 016d5822, 356b7f3c, 8d2c1234, ad4c5678, 11229abc, 3c01def0, 0c123456, 02a00008
//     at addrs 3000..301c.
//  3. out_ready=0 with 5 pushes (FIFO_DEPTH=4) -> in_ready=0 after 4th accept, 5th held.
//     Then pop 1 -> 5th accepted next edge, order preserved.
//  4. in_kind=12 between two NOPs -> err=1, only 2 words out at 3000 and 3004.
//  5. Fill 3 words, assert reset mid-cycle -> out_valid=0 immediately.
//     After release, a new ADD is tagged 00003000; count=0 and err=0.
//  6. Preload address counter near FFFF_FFFC via BASE_ADDR=FFFF_FFFC -> addrs FFFFFFFC then 00000000.
//     Stream 65540 pops -> count holds FFFF.

Source files
------------

// File: rtl/instr_encoder.sv
// =============================================================================
// instr_encoder : packs decoded MIPS fields into 32-bit words, FIFO-buffered
// Revision 1.0
// =============================================================================
`default_nettype none

module instr_encoder #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_kind,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_index,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic [15:0] count,
  output logic        err
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(FIFO_DEPTH);

  logic [31:0]   mem_instr_q [FIFO_DEPTH];
  logic [31:0]   mem_addr_q  [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   occ_q, occ_d;
  logic [31:0]   addr_q;
  logic [15:0]   count_q;
  logic          err_q;

  logic [31:0]   enc_w;
  logic          legal_w;
  logic          full_w, empty_w, accept_w, push_w, pop_w;

  always_comb begin
    enc_w   = 32'h0;
    legal_w = 1'b1;
    case (in_kind)
      4'd0: enc_w = 32'h0;
      4'd1: enc_w = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h20};
      4'd2: enc_w = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h22};
      4'd3: enc_w = {6'h0D, in_rs, in_rt, in_imm};
      4'd4: enc_w = {6'h23, in_rs, in_rt, in_imm};
      4'd5: enc_w = {6'h2B, in_rs, in_rt, in_imm};
      4'd6: enc_w = {6'h04, in_rs, in_rt, in_imm};
      4'd7: enc_w = {6'h0F, 5'd0, in_rt, in_imm};
      4'd8: enc_w = {6'h03, in_index};
      4'd9: enc_w = {6'h00, in_rs, 15'd0, 6'h08};
      default: legal_w = 1'b0;
    endcase
  end

  assign full_w    = (occ_q == C_DEPTH);
  assign empty_w   = (occ_q == '0);
  assign in_ready  = !full_w;
  assign out_valid = !empty_w;
  assign accept_w  = in_valid && in_ready;
  // Illegal kinds complete the handshake but never reach the FIFO.
  assign push_w    = accept_w && legal_w;
  assign pop_w     = out_valid && out_ready;

  always_comb begin
    occ_d = occ_q;
    if (push_w && !pop_w)
      occ_d = occ_q + (AW+1)'(1);
    else if (!push_w && pop_w)
      occ_d = occ_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      occ_q   <= '0;
      addr_q  <= BASE_ADDR;
      count_q <= 16'h0;
      err_q   <= 1'b0;
    end else begin
      occ_q <= occ_d;
      if (push_w) begin
        wptr_q <= wptr_q + AW'(1);
        addr_q <= addr_q + 32'd4;
      end
      if (pop_w) begin
        rptr_q <= rptr_q + AW'(1);
        if (count_q != 16'hFFFF)
          count_q <= count_q + 16'd1;
      end
      if (accept_w && !legal_w)
        err_q <= 1'b1;
    end
  end

  // Storage needs no reset: reads are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_w) begin
      mem_instr_q[wptr_q] <= enc_w;
      mem_addr_q[wptr_q]  <= addr_q;
    end
  end

  assign out_instr = empty_w ? 32'h0 : mem_instr_q[rptr_q];
  assign out_addr  = empty_w ? 32'h0 : mem_addr_q[rptr_q];
  assign count     = count_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// =============================================================================
// tb_instr_encoder : scoreboard bench for instr_encoder
// Revision 1.0
// =============================================================================
`default_nettype none

module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_kind = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_index = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_addr;
  logic [15:0] count;
  logic        err;

  logic        rst2 = 1'b0;
  logic        in_ready2, out_valid2, err2;
  logic [31:0] out_instr2, out_addr2;
  logic [15:0] count2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] exp_q[$];
  logic [31:0] exp_addr = 32'h0000_3000;
  logic        err_exp  = 1'b0;
  int          sb_pops  = 0;

  always #5 clk = ~clk;

  instr_encoder #(.FIFO_DEPTH(4), .BASE_ADDR(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_index(in_index), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .count(count), .err(err)
  );

  instr_encoder #(.FIFO_DEPTH(4), .BASE_ADDR(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(rst2), .in_valid(1'b1), .in_ready(in_ready2),
    .in_kind(4'd0), .in_rs(5'd0), .in_rt(5'd0), .in_rd(5'd0),
    .in_imm(16'd0), .in_index(26'd0), .out_valid(out_valid2),
    .out_ready(1'b1), .out_instr(out_instr2), .out_addr(out_addr2),
    .count(count2), .err(err2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out", name);
  endtask

  // Reference encoding from the field layout, using shifts and sums.
  function automatic logic [32:0] ref_enc(input int k, input int rs, input int rt,
                                          input int rd, input int imm, input int idx);
    int unsigned w;
    w = 0;
    case (k)
      0: w = 0;
      1: w = (rs << 21) + (rt << 16) + (rd << 11) + 32;
      2: w = (rs << 21) + (rt << 16) + (rd << 11) + 34;
      3: w = (13 << 26) + (rs << 21) + (rt << 16) + imm;
      4: w = (35 << 26) + (rs << 21) + (rt << 16) + imm;
      5: w = (43 << 26) + (rs << 21) + (rt << 16) + imm;
      6: w = (4 << 26) + (rs << 21) + (rt << 16) + imm;
      7: w = (15 << 26) + (rt << 16) + imm;
      8: w = (3 << 26) + idx;
      9: w = (rs << 21) + 8;
      default: return {1'b0, 32'h0};
    endcase
    return {1'b1, w};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int k, input int rs, input int rt, input int rd,
                      input int imm, input int idx);
    logic [32:0] r;
    logic done;
    in_kind = 4'(k); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_imm = 16'(imm); in_index = 26'(idx);
    in_valid = 1'b1;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        r = ref_enc(k, rs, rt, rd, imm, idx);
        if (r[32]) begin
          exp_q.push_back({r[31:0], exp_addr});
          exp_addr = exp_addr + 32'd4;
        end else begin
          err_exp = 1'b1;
        end
        done = 1'b1;
      end
    end
    if (!done) timeout("send_accept");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) timeout("drain");
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic check_clear);
    @(posedge clk); #3;
    reset = 1'b0;
    exp_q.delete();
    exp_addr = 32'h0000_3000;
    err_exp  = 1'b0;
    sb_pops  = 0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    if (check_clear) begin
      check("rst_count", 64'(count), 64'd0);
      check("rst_err", 64'(err), 64'd0);
    end
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor for the main instance.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_pop: got instr %h addr %h required none", out_instr, out_addr);
        end else begin
          e = exp_q.pop_front();
          check("instr", 64'(out_instr), 64'(e[63:32]));
          check("addr", 64'(out_addr), 64'(e[31:0]));
          check("count_at_pop", 64'(count), 64'(sb_pops));
          sb_pops++;
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      begin : main_seq
        #1;
        check("init_out_valid", 64'(out_valid), 64'd0);
        check("init_out_addr", 64'(out_addr), 64'd0);
        check("init_count", 64'(count), 64'd0);
        check("init_err", 64'(err), 64'd0);
        @(posedge clk); @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        check("init_in_ready", 64'(in_ready), 64'd1);

        // single ADD, one-cycle latency
        out_ready = 1'b1;
        send(1, 9, 10, 10, 0, 0);
        check("latency_out_valid", 64'(out_valid), 64'd1);
        wait_drain();
        check("count_after_one", 64'(count), 64'd1);

        // every legal kind in sequence, with unused fields set to noise
        do_reset(1'b0);
        send(2, 11, 13, 11, 16'hffff, 0);
        send(3, 11, 11, 31, 16'h7f3c, 26'h3ffffff);
        send(4, 9, 12, 7, 16'h1234, 0);
        send(5, 10, 12, 0, 16'h5678, 0);
        send(6, 9, 2, 5, 16'h9abc, 0);
        send(7, 17, 1, 3, 16'hdef0, 0);
        send(8, 31, 31, 31, 16'hffff, 26'h0123456);
        send(9, 21, 7, 9, 16'h5555, 0);
        wait_drain();

        // illegal kind between two NOPs
        do_reset(1'b1);
        send(0, 0, 0, 0, 0, 0);
        send(12, 1, 2, 3, 4, 5);
        send(0, 0, 0, 0, 0, 0);
        wait_drain();
        check("err_sticky", 64'(err), 64'd1);
        check("count_two_words", 64'(count), 64'd2);

        // reset mid-stream discards buffered words
        out_ready = 1'b0;
        send(1, 1, 2, 3, 0, 0);
        send(3, 4, 5, 0, 16'h0042, 0);
        send(8, 0, 0, 0, 0, 26'h0000abc);
        do_reset(1'b1);
        out_ready = 1'b1;
        send(1, 9, 10, 10, 0, 0);
        wait_drain();

        // full FIFO back-pressure with no bypass
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(3, i, i + 1, 0, 16'h1000 + i, 0);
        #1;
        check("full_in_ready", 64'(in_ready), 64'd0);
        fork
          send(4, 7, 8, 0, 16'h0005, 0);
          begin
            repeat (3) @(negedge clk);
            check("held_in_ready", 64'(in_ready), 64'd0);
            check("held_in_valid", 64'(in_valid), 64'd1);
            @(posedge clk); #1;
            out_ready = 1'b1;
            @(negedge clk);
            check("no_bypass", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
            out_ready = 1'b0;
          end
        join
        check("fifth_buffered", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        wait_drain();

        // randomized traffic with random back-pressure
        fork
          for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) begin
              @(posedge clk); #1;
            end
            send($urandom_range(0, 11), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 16'hffff), $urandom_range(0, 26'h3ffffff));
          end
          for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
          end
        join
        out_ready = 1'b1;
        wait_drain();
        check("err_random", 64'(err), 64'(err_exp));
        check("count_random", 64'(count), 64'(sb_pops));
      end

      begin : wrap_and_saturate
        int pops2;
        logic hit;
        pops2 = 0;
        hit = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst2 = 1'b1;
        for (int c = 0; c < 70000 && !hit; c++) begin
          @(negedge clk);
          if (out_valid2) begin
            if (pops2 == 0)     check("wrap_addr0", 64'(out_addr2), 64'hFFFF_FFFC);
            if (pops2 == 1)     check("wrap_addr1", 64'(out_addr2), 64'h0);
            if (pops2 == 100)   check("count_100", 64'(count2), 64'd100);
            if (pops2 == 65534) check("count_65534", 64'(count2), 64'd65534);
            pops2++;
            if (pops2 == 65540) hit = 1'b1;
          end
        end
        if (!hit) timeout("stream_pops");
        @(negedge clk);
        check("count_saturated", 64'(count2), 64'hFFFF);
        check("nop_err_clear", 64'(err2), 64'd0);
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
